// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with two write ports,
// write-to-read bypass, optional hardwired zero entry and a hardware
// clear sequencer (runs after reset and on clr_req, reported via clr_busy).
// Optional feature macro: REGFILE_SCOREBOARD_EN adds a per-entry pending
// vector and exposes it per read port on rd_pend.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | normal operation, writes and issues accepted
// ST_CLEAR | zeroing one entry per cycle, writes dropped, reads return 0
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     wr_drop,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_addr,
  output logic [NUM_RD-1:0]        rd_pend
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic              wr_drop_q, wr_drop_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic idle;
  logic zero0, zero1;
  logic same_addr;
  logic wr_ok0, wr_ok1;
  logic collide_drop;

  assign idle      = (state_q == ST_IDLE);
  assign clr_busy  = (state_q == ST_CLEAR);
  assign wr_drop   = wr_drop_q;
  assign zero0     = (ZERO_REG != 0) && (waddr0 == '0);
  assign zero1     = (ZERO_REG != 0) && (waddr1 == '0);
  assign same_addr = (waddr0 == waddr1);

  // Port 1 has priority on an address collision; zero-entry writes vanish.
  assign wr_ok1       = we1 && idle && !rst && !zero1;
  assign wr_ok0       = we0 && idle && !rst && !zero0 && !(we1 && same_addr);
  assign collide_drop = idle && we0 && we1 && same_addr && !zero0;

  // State and clear-index registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // Next-state logic for the clear sequencer and the drop flag
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    wr_drop_d = collide_drop || (!idle && (we0 || we1));
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
        end
      end
      ST_CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == '1) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_idx_d = '0;
      end
    endcase
  end

  // Storage: zeroed entry by entry while clearing, otherwise accepted writes
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_CLEAR) begin
        mem_q[clr_idx_q] <= '0;
      end else begin
        if (wr_ok0) mem_q[waddr0] <= wdata0;
        if (wr_ok1) mem_q[waddr1] <= wdata1;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = raddr[k*ADDR_W +: ADDR_W];

    // Combinational read with port-1-first bypass of same-cycle writes
    always_comb begin
      rd = mem_q[ra];
      if (clr_busy) begin
        rd = '0;
      end else if ((ZERO_REG != 0) && (ra == '0)) begin
        rd = '0;
      end else if (we1 && (waddr1 == ra)) begin
        rd = wdata1;
      end else if (we0 && (waddr0 == ra)) begin
        rd = wdata0;
      end
    end

    assign rdata[k*DATA_W +: DATA_W] = rd;
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0] pend_q, pend_d;
  logic             issue_ok;

  assign issue_ok = issue_valid && idle && !rst &&
                    !((ZERO_REG != 0) && (issue_addr == '0));

  // Pending vector: writes clear, an issue in the same cycle sets again
  always_comb begin
    pend_d = pend_q;
    if (wr_ok0) pend_d[waddr0] = 1'b0;
    if (wr_ok1) pend_d[waddr1] = 1'b0;
    if (issue_ok) pend_d[issue_addr] = 1'b1;
    if (idle && clr_req) pend_d = '0;
  end

  // Pending vector register
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_pend
    logic [ADDR_W-1:0] ra;
    logic              wr_hit;

    assign ra         = raddr[k*ADDR_W +: ADDR_W];
    assign wr_hit     = (wr_ok0 && (waddr0 == ra)) || (wr_ok1 && (waddr1 == ra));
    assign rd_pend[k] = pend_q[ra] && !wr_hit;
  end
`else
  logic unused_issue;

  assign unused_issue = ^{issue_valid, issue_addr};
  assign rd_pend      = '0;
`endif

endmodule
